alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_issue.sv | 70 +++++++
 tb/tb_alu_issue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Issue-side bundle for alu_issue: instruction handshake, adder operand/result
// path, carry flag and register-file debug port.
interface alu_issue_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic [7:0] instr_imm;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       op_cin;
    logic       op_valid;
    logic [7:0] res_sum;
    logic       res_cout;
    logic       carry_flag;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs, instr_imm,
        input  res_sum, res_cout, dbg_sel,
        output instr_ready, op_a, op_b, op_cin, op_valid, carry_flag, dbg_data
    );

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs, instr_imm,
        output res_sum, res_cout, dbg_sel,
        input  instr_ready, op_a, op_b, op_cin, op_valid, carry_flag, dbg_data
    );
endinterface

// File: rtl/alu_issue.sv
// Two-state issue unit: 4x8-bit register file feeding an external adder,
// one ADD/ADC in flight at a time, result written back on the EXEC exit edge.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    alu_issue_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;

    logic [0:0]      r_state;
    logic [3:0][7:0] r_regs;
    logic            r_carry;
    logic [7:0]      r_op_a;
    logic [7:0]      r_op_b;
    logic            r_op_cin;
    logic [1:0]      r_rd;
    logic            w_accept;

    assign w_accept = bus.instr_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_regs   <= '0;
            r_carry  <= 1'b0;
            r_op_a   <= 8'h00;
            r_op_b   <= 8'h00;
            r_op_cin <= 1'b0;
            r_rd     <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (bus.instr_op)
                            OP_ADD, OP_ADC: begin
                                // Both operands read before any write, so rd==rs sees the old value
                                r_op_a   <= r_regs[bus.instr_rd];
                                r_op_b   <= r_regs[bus.instr_rs];
                                r_op_cin <= (bus.instr_op == OP_ADC) ? r_carry : 1'b0;
                                r_rd     <= bus.instr_rd;
                                r_state  <= S_EXEC;
                            end
                            OP_LDI:  r_regs[bus.instr_rd] <= bus.instr_imm;
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    r_regs[r_rd] <= bus.res_sum;
                    r_carry      <= bus.res_cout;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.instr_ready = (r_state == S_IDLE);
    assign bus.op_valid    = (r_state == S_EXEC);
    assign bus.op_a        = r_op_a;
    assign bus.op_b        = r_op_b;
    assign bus.op_cin      = r_op_cin;
    assign bus.carry_flag  = r_carry;
    assign bus.dbg_data    = r_regs[bus.dbg_sel];
endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized
// instruction stream checked against an arithmetic register-file model.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue dut (.clk(clk), .rst(rst), .bus(bus.slave));

    // Downstream adder
    logic [8:0] add9;
    assign add9         = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {8'd0, bus.op_cin};
    assign bus.res_sum  = add9[7:0];
    assign bus.res_cout = add9[8];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_regs [4];
    logic       m_carry;
    logic [7:0] last_a, last_b;
    logic       last_cin;

    task automatic model_reset();
        for (int r = 0; r < 4; r++) m_regs[r] = 8'h00;
        m_carry = 1'b0; last_a = 8'h00; last_b = 8'h00; last_cin = 1'b0;
    endtask

    // Applies one instruction to the model; returns the operands an ADD/ADC presents
    task automatic model_apply(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                               input logic [7:0] imm, output logic [7:0] ea, output logic [7:0] eb,
                               output logic ec);
        int s;
        ea = last_a; eb = last_b; ec = last_cin;
        if (op == 2'b00 || op == 2'b01) begin
            ea = m_regs[rd]; eb = m_regs[rs];
            ec = (op == 2'b01) ? m_carry : 1'b0;
            s  = int'(ea) + int'(eb) + int'(ec);
            m_regs[rd] = 8'(s % 256);
            m_carry    = (s >= 256);
            last_a = ea; last_b = eb; last_cin = ec;
        end else if (op == 2'b10) begin
            m_regs[rd] = imm;
        end
    endtask

    // Presents one instruction for a single edge, returns #1 after that edge
    task automatic drive(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm);
        bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_rd = rd;
        bus.instr_rs = rs; bus.instr_imm = imm;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0; bus.instr_op = 2'b11; bus.instr_rd = 2'd0;
        bus.instr_rs = 2'd0; bus.instr_imm = 8'h00; bus.dbg_sel = 2'd0;
        model_reset();
        #12;
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.instr_ready); end
        n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %b want 0", bus.op_valid); end
        n_checks++; if ({bus.op_a, bus.op_b, bus.op_cin} !== 17'h0) begin n_fail++; $display("FAIL reset_ops got %h/%h/%b want 0", bus.op_a, bus.op_b, bus.op_cin); end
        n_checks++; if (bus.carry_flag !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", bus.carry_flag); end
        for (int r = 0; r < 4; r++) begin
            bus.dbg_sel = 2'(r); #1;
            n_checks++; if (bus.dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d got %h want 00", r, bus.dbg_data); end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", bus.instr_ready); end
    endtask

    task automatic test_add();
        logic [7:0] ea, eb; logic ec;
        model_apply(2'b10, 2'd0, 2'd0, 8'h12, ea, eb, ec); drive(2'b10, 2'd0, 2'd0, 8'h12);
        model_apply(2'b10, 2'd1, 2'd0, 8'h34, ea, eb, ec); drive(2'b10, 2'd1, 2'd0, 8'h34);
        model_apply(2'b00, 2'd0, 2'd1, 8'h00, ea, eb, ec); drive(2'b00, 2'd0, 2'd1, 8'h00);
        n_checks++; if (bus.op_valid !== 1'b1 || bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL add_exec valid/ready got %b/%b want 1/0", bus.op_valid, bus.instr_ready); end
        n_checks++; if ({bus.op_a, bus.op_b, bus.op_cin} !== {8'h12, 8'h34, 1'b0}) begin n_fail++; $display("FAIL add_ops got %h/%h/%b want 12/34/0", bus.op_a, bus.op_b, bus.op_cin); end
        @(posedge clk); #1;
        n_checks++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL add_one_cycle op_valid got %b want 0", bus.op_valid); end
        bus.dbg_sel = 2'd0; #1;
        n_checks++; if (bus.dbg_data !== 8'h46 || bus.carry_flag !== 1'b0) begin n_fail++; $display("FAIL add_result got %h c%b want 46 c0", bus.dbg_data, bus.carry_flag); end
    endtask

    task automatic test_carry_chain();
        logic [7:0] ea, eb; logic ec;
        model_apply(2'b10, 2'd2, 2'd0, 8'hFF, ea, eb, ec); drive(2'b10, 2'd2, 2'd0, 8'hFF);
        model_apply(2'b10, 2'd3, 2'd0, 8'h01, ea, eb, ec); drive(2'b10, 2'd3, 2'd0, 8'h01);
        model_apply(2'b00, 2'd2, 2'd3, 8'h00, ea, eb, ec); drive(2'b00, 2'd2, 2'd3, 8'h00);
        @(posedge clk); #1;
        bus.dbg_sel = 2'd2; #1;
        n_checks++; if (bus.dbg_data !== 8'h00 || bus.carry_flag !== 1'b1) begin n_fail++; $display("FAIL wrap_result got %h c%b want 00 c1", bus.dbg_data, bus.carry_flag); end
        model_apply(2'b01, 2'd3, 2'd3, 8'h00, ea, eb, ec); drive(2'b01, 2'd3, 2'd3, 8'h00);
        n_checks++; if ({bus.op_a, bus.op_b, bus.op_cin} !== {8'h01, 8'h01, 1'b1}) begin n_fail++; $display("FAIL adc_ops got %h/%h/%b want 01/01/1", bus.op_a, bus.op_b, bus.op_cin); end
        @(posedge clk); #1;
        bus.dbg_sel = 2'd3; #1;
        n_checks++; if (bus.dbg_data !== 8'h03 || bus.carry_flag !== 1'b0) begin n_fail++; $display("FAIL adc_result got %h c%b want 03 c0", bus.dbg_data, bus.carry_flag); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea, eb; logic ec;
        model_apply(2'b10, 2'd0, 2'd0, 8'h10, ea, eb, ec); drive(2'b10, 2'd0, 2'd0, 8'h10);
        model_apply(2'b10, 2'd1, 2'd0, 8'h05, ea, eb, ec); drive(2'b10, 2'd1, 2'd0, 8'h05);
        model_apply(2'b00, 2'd0, 2'd1, 8'h00, ea, eb, ec);
        model_apply(2'b00, 2'd0, 2'd1, 8'h00, ea, eb, ec);
        bus.dbg_sel = 2'd0;
        bus.instr_valid = 1'b1; bus.instr_op = 2'b00; bus.instr_rd = 2'd0; bus.instr_rs = 2'd1;
        @(posedge clk); #1;
        n_checks++; if (bus.instr_ready !== 1'b0 || bus.op_a !== 8'h10) begin n_fail++; $display("FAIL b2b_first got rdy%b a=%h want rdy0 a=10", bus.instr_ready, bus.op_a); end
        @(posedge clk); #1;
        n_checks++; if (bus.op_valid !== 1'b0 || bus.dbg_data !== 8'h15) begin n_fail++; $display("FAIL b2b_gap got v%b r0=%h want v0 r0=15", bus.op_valid, bus.dbg_data); end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        n_checks++; if (bus.op_valid !== 1'b1 || bus.op_a !== 8'h15) begin n_fail++; $display("FAIL b2b_second got v%b a=%h want v1 a=15", bus.op_valid, bus.op_a); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (bus.dbg_data !== m_regs[0] || bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_final got r0=%h v%b want r0=%h v0", bus.dbg_data, bus.op_valid, m_regs[0]); end
    endtask

    task automatic test_reset_mid_exec();
        logic [7:0] ea, eb; logic ec;
        model_apply(2'b10, 2'd0, 2'd0, 8'h80, ea, eb, ec); drive(2'b10, 2'd0, 2'd0, 8'h80);
        drive(2'b00, 2'd0, 2'd0, 8'h00);
        bus.dbg_sel = 2'd0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.op_valid !== 1'b0 || bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_exec_state got v%b rdy%b want v0 rdy1", bus.op_valid, bus.instr_ready); end
        n_checks++; if (bus.dbg_data !== 8'h00 || bus.carry_flag !== 1'b0 || bus.op_a !== 8'h00) begin n_fail++; $display("FAIL rst_exec_clear got r0=%h c%b a=%h want 00 c0 00", bus.dbg_data, bus.carry_flag, bus.op_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++; if (bus.dbg_data !== 8'h00 || bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_no_writeback got r0=%h rdy%b want 00 rdy1", bus.dbg_data, bus.instr_ready); end
    endtask

    task automatic test_nop_ldi();
        logic [7:0] ea, eb; logic ec;
        model_apply(2'b10, 2'd0, 2'd0, 8'hF0, ea, eb, ec); drive(2'b10, 2'd0, 2'd0, 8'hF0);
        model_apply(2'b10, 2'd1, 2'd0, 8'h20, ea, eb, ec); drive(2'b10, 2'd1, 2'd0, 8'h20);
        model_apply(2'b00, 2'd0, 2'd1, 8'h00, ea, eb, ec); drive(2'b00, 2'd0, 2'd1, 8'h00);
        @(posedge clk); #1;
        model_apply(2'b11, 2'd1, 2'd2, 8'h77, ea, eb, ec); drive(2'b11, 2'd1, 2'd2, 8'h77);
        n_checks++; if (bus.op_valid !== 1'b0 || bus.carry_flag !== 1'b1 || bus.op_a !== 8'hF0) begin n_fail++; $display("FAIL nop_state got v%b c%b a=%h want v0 c1 a=f0", bus.op_valid, bus.carry_flag, bus.op_a); end
        for (int r = 0; r < 4; r++) begin
            bus.dbg_sel = 2'(r); #1;
            n_checks++; if (bus.dbg_data !== m_regs[r]) begin n_fail++; $display("FAIL nop_reg%0d got %h want %h", r, bus.dbg_data, m_regs[r]); end
        end
        @(posedge clk); #1;
        model_apply(2'b10, 2'd1, 2'd0, 8'hAA, ea, eb, ec); drive(2'b10, 2'd1, 2'd0, 8'hAA);
        bus.dbg_sel = 2'd1; #1;
        n_checks++; if (bus.dbg_data !== 8'hAA || bus.carry_flag !== 1'b1) begin n_fail++; $display("FAIL ldi_carry got r1=%h c%b want aa c1", bus.dbg_data, bus.carry_flag); end
    endtask

    task automatic test_random();
        logic [7:0] ea, eb, imm; logic ec; logic [1:0] op, rd, rs;
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3)); rd = 2'($urandom_range(0, 3));
            rs = 2'($urandom_range(0, 3)); imm = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            model_apply(op, rd, rs, imm, ea, eb, ec);
            drive(op, rd, rs, imm);
            if (op == 2'b00 || op == 2'b01) begin
                n_checks++; if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_cin} !== {1'b1, ea, eb, ec}) begin n_fail++; $display("FAIL rnd_ops[%0d] got v%b %h/%h/%b want v1 %h/%h/%b", i, bus.op_valid, bus.op_a, bus.op_b, bus.op_cin, ea, eb, ec); end
                // Junk presented during EXEC must be ignored
                bus.instr_valid = 1'($urandom_range(0, 1)); bus.instr_op = 2'($urandom_range(0, 3));
                bus.instr_rd = 2'($urandom_range(0, 3)); bus.instr_imm = 8'($urandom_range(0, 255));
                @(posedge clk); #1;
                bus.instr_valid = 1'b0;
            end else begin
                n_checks++; if ({bus.op_a, bus.op_b, bus.op_cin} !== {last_a, last_b, last_cin}) begin n_fail++; $display("FAIL rnd_hold[%0d] got %h/%h/%b want %h/%h/%b", i, bus.op_a, bus.op_b, bus.op_cin, last_a, last_b, last_cin); end
            end
            n_checks++; if (bus.op_valid !== 1'b0 || bus.instr_ready !== 1'b1 || bus.carry_flag !== m_carry) begin n_fail++; $display("FAIL rnd_idle[%0d] got v%b rdy%b c%b want v0 rdy1 c%b", i, bus.op_valid, bus.instr_ready, bus.carry_flag, m_carry); end
            for (int r = 0; r < 4; r++) begin
                bus.dbg_sel = 2'(r); #1;
                n_checks++; if (bus.dbg_data !== m_regs[r]) begin n_fail++; $display("FAIL rnd_reg[%0d] r%0d got %h want %h", i, r, bus.dbg_data, m_regs[r]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid_exec();
        test_nop_ldi();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
